// File: rtl/sseg_pkg.sv
// Shared types and constants for the segment parallel-to-serial shifter.
// Holds the FSM state encoding, the default frame width and the half-bit period helper.
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam int DATA_W_DEF  = 64;
  localparam int CLK_DIV_DEF = 2;
  localparam int H_DEF       = 1 << CLK_DIV_DEF;

  // Number of clk cycles in one serial-clock phase (half a bit).
  function automatic int half_cyc(input int clk_div);
    return 1 << clk_div;
  endfunction

endpackage

// File: rtl/sseg_tick_gen.sv
// Half-bit divider: tick marks the last cycle of each serial-clock phase, phase is the s_clk level.
// Zero latency; counter is held at zero whenever run is low, so every frame starts phase-aligned.
module sseg_tick_gen
  import sseg_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick,
  output logic phase
);

  localparam logic [CLK_DIV:0] LO_MASK = (CLK_DIV+1)'(half_cyc(CLK_DIV) - 1);

  logic [CLK_DIV:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run) cnt_d = cnt_q + (CLK_DIV+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // With CLK_DIV=0 the mask is empty and every running cycle is a phase end.
  assign tick  = run && ((cnt_q & LO_MASK) == LO_MASK);
  assign phase = cnt_q[CLK_DIV];

endmodule

// File: rtl/sseg_p2s.sv
// Shifts a captured segment word MSB-first into chained 595-style registers, then pulses s_pen; busy (2*DATA_W+1)*H cycles.
// start is only sampled while idle (no queuing); SSEG_P2S_AUTO_REFRESH_EN adds an idle-timeout self-start.
module sseg_p2s
  import sseg_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int REFRESH_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] par_data,
  output logic              busy,
  output logic              done,
  output logic              s_clk,
  output logic              s_dat,
  output logic              s_pen,
  output logic              s_clr_n
);

  localparam int CNT_W = $clog2(DATA_W);

  if (REFRESH_CYC < 1) begin : g_bad_cfg
    $error("sseg_p2s: REFRESH_CYC must be at least 1");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  bit_q, bit_d;
  logic              done_q, done_d;
  logic              clr_n_q;
  logic              run, tick, phase, launch;

  assign run = (state_q != IDLE);

  sseg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick),
    .phase (phase)
  );

`ifdef SSEG_P2S_AUTO_REFRESH_EN
  localparam int IDLE_W = $clog2(REFRESH_CYC + 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              refresh;

  // Counts consecutive idle cycles; any launch or non-idle cycle restarts it.
  assign refresh = (idle_q == IDLE_W'(REFRESH_CYC - 1));

  always_comb begin
    idle_d = '0;
    if (state_q == IDLE && !start && !refresh) idle_d = idle_q + IDLE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end

  assign launch = start || refresh;
`else
  assign launch = start;
`endif

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          sreg_d  = par_data;
          bit_d   = CNT_W'(DATA_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Bit ends on the last cycle of the high s_clk phase.
        if (tick && phase) begin
          sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
          bit_d  = bit_q - CNT_W'(1);
          if (bit_q == '0) state_d = LATCH;
        end
      end
      LATCH: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
      clr_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      clr_n_q <= 1'b1;
    end
  end

  // Outputs decode straight from reset-cleared state so an abort zeroes them immediately.
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign s_clk   = (state_q == SHIFT) && phase;
  assign s_dat   = (state_q == SHIFT) && sreg_q[DATA_W-1];
  assign s_pen   = (state_q == LATCH);
  assign s_clr_n = clr_n_q;

endmodule

// File: tb/tb_sseg_p2s.sv
// Directed bench for sseg_p2s: three instances (H=1, H=4, and an auto-refresh unit with start tied low).
module tb_sseg_p2s;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_start, b_start, r_start;
  logic [63:0] a_data, b_data, r_data;
  logic        a_busy, a_done, a_sclk, a_sdat, a_spen, a_clrn;
  logic        b_busy, b_done, b_sclk, b_sdat, b_spen, b_clrn;
  logic        r_busy, r_done, r_sclk, r_sdat, r_spen, r_clrn;

  sseg_p2s #(.DATA_W(64), .CLK_DIV(0), .REFRESH_CYC(1000000)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .par_data(a_data),
    .busy(a_busy), .done(a_done), .s_clk(a_sclk), .s_dat(a_sdat), .s_pen(a_spen), .s_clr_n(a_clrn));

  sseg_p2s #(.DATA_W(64), .CLK_DIV(2), .REFRESH_CYC(1000000)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .par_data(b_data),
    .busy(b_busy), .done(b_done), .s_clk(b_sclk), .s_dat(b_sdat), .s_pen(b_spen), .s_clr_n(b_clrn));

  sseg_p2s #(.DATA_W(64), .CLK_DIV(0), .REFRESH_CYC(10)) dut_r (
    .clk(clk), .rst_n(rst_n), .start(r_start), .par_data(r_data),
    .busy(r_busy), .done(r_done), .s_clk(r_sclk), .s_dat(r_sdat), .s_pen(r_spen), .s_clr_n(r_clrn));

  int   sel;
  logic m_busy, m_done, m_sclk, m_sdat, m_spen;
  assign m_busy = (sel == 1) ? b_busy : a_busy;
  assign m_done = (sel == 1) ? b_done : a_done;
  assign m_sclk = (sel == 1) ? b_sclk : a_sclk;
  assign m_sdat = (sel == 1) ? b_sdat : a_sdat;
  assign m_spen = (sel == 1) ? b_spen : a_spen;

  int n_pass, n_total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_in(input int s, input logic st, input logic [63:0] d);
    if (s == 1) begin b_start = st; b_data = d; end
    else        begin a_start = st; a_data = d; end
  endtask

  // Launches one frame from the current negedge and checks it end to end.
  // Returns on the negedge of the done cycle; hold keeps start high for back-to-back frames.
  task automatic run_frame(input int s, input logic [63:0] data, input logic [63:0] exp_word,
                           input int exp_len, input bit disturb, input bit hold, input string tag);
    int h, idx, rises, pen_n, ones, dones, bad_latch, bad_stab;
    logic [63:0] word;
    logic prev_clk;
    logic dat_h [1024];
    logic clk_h [1024];
    h = (s == 1) ? 4 : 1;
    sel = s;
    idx = 0; rises = 0; pen_n = 0; ones = 0; dones = 0; bad_latch = 0; bad_stab = 0;
    word = '0; prev_clk = 1'b0;
    set_in(s, 1'b1, data);
    @(negedge clk);
    check({tag, "_busy_rise"}, m_busy, 1);
    set_in(s, hold, ~data);
    while (m_busy && idx < 1024) begin
      dat_h[idx] = m_sdat;
      clk_h[idx] = m_sclk;
      if (m_sclk && !prev_clk) begin
        rises++;
        word = {word[62:0], m_sdat};
      end
      prev_clk = m_sclk;
      ones  += int'(m_sdat);
      pen_n += int'(m_spen);
      dones += int'(m_done);
      if (m_spen && (m_sdat || m_sclk)) bad_latch++;
      if (disturb && idx == 50) set_in(s, 1'b1, data ^ 64'h5A5A_5A5A_5A5A_5A5A);
      if (disturb && idx == 51) set_in(s, hold, ~data);
      idx++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, idx, exp_len);
    check({tag, "_done_at_fall"}, m_done, 1);
    check({tag, "_done_while_busy"}, dones, 0);
    check({tag, "_rises"}, rises, 64);
    check({tag, "_word"}, word, exp_word);
    check({tag, "_pen_len"}, pen_n, h);
    check({tag, "_ones_cycles"}, ones, $countones(exp_word) * 2 * h);
    check({tag, "_latch_quiet"}, bad_latch, 0);
    for (int r = 1; r < idx; r++) begin
      if (clk_h[r] && !clk_h[r-1]) begin
        for (int j = r - h; j < r + h; j++)
          if (j >= 0 && j < idx && dat_h[j] !== dat_h[r]) bad_stab++;
      end
    end
    check({tag, "_dat_stable"}, bad_stab, 0);
  endtask

  typedef struct {
    int          sel;
    logic [63:0] data;
    logic [63:0] exp_word;
    int          exp_len;
    bit          disturb;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int cnt, hi, lo, pen_seen;
    logic [63:0] d;
    n_pass = 0; n_total = 0; sel = 0;
    a_start = 0; b_start = 0; r_start = 0;
    a_data = '0; b_data = '0; r_data = 64'hF0F0_0F0F_FF00_00FF;
    rst_n = 1'b0;

    vecs[0] = '{0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 129, 1'b0};
    vecs[1] = '{1, 64'hA5A5_F00F_0123_4567, 64'hA5A5_F00F_0123_4567, 516, 1'b0};
    vecs[2] = '{0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 129, 1'b1};
    vecs[3] = '{1, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 516, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_a_outputs", {a_busy, a_done, a_sclk, a_sdat, a_spen, a_clrn}, 6'b0);
    check("rst_b_outputs", {b_busy, b_done, b_sclk, b_sdat, b_spen, b_clrn}, 6'b0);
    rst_n = 1'b1;
    #1;
    check("clrn_before_edge", a_clrn, 0);
    @(negedge clk);
    check("clrn_after_edge", a_clrn, 1);
    check("idle_after_rst", {a_busy, b_busy, b_done}, 3'b0);

    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].sel, vecs[i].data, vecs[i].exp_word, vecs[i].exp_len,
                vecs[i].disturb, 1'b0, $sformatf("v%0d", i));
      repeat (3) @(negedge clk);
    end

    // Back-to-back frames with start held high, alternating payloads.
    for (int f = 0; f < 4; f++) begin
      d = f[0] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
      run_frame(0, d, d, 129, 1'b0, (f < 3), $sformatf("b2b%0d", f));
    end
    set_in(0, 1'b0, '0);
    @(negedge clk);
    check("b2b_stops", a_busy, 0);

    // Reset during bit 20 of an H=4 frame.
    sel = 1;
    set_in(1, 1'b1, 64'h1357_9BDF_2468_ACE0);
    @(negedge clk);
    set_in(1, 1'b0, 64'h1357_9BDF_2468_ACE0);
    repeat (162) @(negedge clk);
    check("abort_mid_busy", b_busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs_zero", {b_busy, b_done, b_sclk, b_sdat, b_spen, b_clrn}, 6'b0);
    pen_seen = 0;
    repeat (3) begin
      @(negedge clk);
      pen_seen += int'(b_spen);
    end
    rst_n = 1'b1;
    #1;
    check("abort_clrn_low", b_clrn, 0);
    @(negedge clk);
    pen_seen += int'(b_spen);
    check("abort_clrn_high", b_clrn, 1);
    check("abort_no_pen", pen_seen, 0);
    check("abort_idle", b_busy, 0);
    run_frame(1, 64'h0F1E_2D3C_4B5A_6978, 64'h0F1E_2D3C_4B5A_6978, 516, 1'b0, 1'b0, "post_rst");

    // Idle auto-refresh unit, start tied low.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef SSEG_P2S_AUTO_REFRESH_EN
    cnt = 0;
    while (!r_busy && cnt < 200) begin @(negedge clk); cnt++; end
    check("auto_first_launch", cnt, 10);
    hi = 0;
    while (r_busy && hi < 400) begin @(negedge clk); hi++; end
    check("auto_busy_len", hi, 129);
    lo = 0;
    while (!r_busy && lo < 200) begin @(negedge clk); lo++; end
    check("auto_idle_gap", lo, 10);
    hi = 0;
    while (r_busy && hi < 400) begin @(negedge clk); hi++; end
    check("auto_period", hi + lo, 139);
`else
    cnt = 0;
    repeat (300) begin @(negedge clk); cnt += int'(r_busy); end
    check("no_auto_launch", cnt, 0);
    check("no_auto_done", r_done, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sseg_p2s.md
Name: sseg_p2s

Overview:
- Parallel-to-serial shifter downstream of the segment-map stage.
- Takes the 64-bit remapped segment word and shifts it MSB-first into the board's chained 8-bit shift registers (74HC595-style), then pulses the latch/enable line.
- Generates its own divided serial clock and exposes a start/busy/done handshake to the display controller.

Parameters:
- DATA_W, 64, number of bits shifted per frame.
- CLK_DIV, 2, half-bit period exponent: H = 2**CLK_DIV clk cycles per serial-clock phase.
- REFRESH_CYC, 1000000, idle cycles before auto-restart (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a frame; sampled only in IDLE.
- par_data  in  DATA_W  segment word from the map stage; captured on accepted start.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame completion.
- s_clk  out  1  serial shift clock to the shift registers.
- s_dat  out  1  serial data, MSB first.
- s_pen  out  1  latch/output-enable pulse after the last bit.
- s_clr_n  out  1  active-low clear to the shift registers.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, shift reg=0, busy=0, done=0, s_clk=0, s_dat=0, s_pen=0, s_clr_n=0. s_clr_n rises to 1 on the first clk edge after rst_n deasserts.
- States: IDLE -> SHIFT -> LATCH -> IDLE.
- IDLE:
  - start=1 at edge t: capture par_data into the shift reg, set bit counter to DATA_W-1, enter SHIFT. busy=1 from t+1.
  - start while busy is ignored; no queuing.
- SHIFT, each bit k (0 = MSB):
  - s_dat = current MSB for 2H cycles, starting at cycle t+1+2kH.
  - s_clk is 0 for the first H cycles and 1 for the next H. The rising s_clk edge is mid-bit, so data is stable H cycles either side.
  - At the end of each bit the shift reg shifts left, filling with 0, and the counter decrements.
  - After bit DATA_W-1, go to LATCH.
- LATCH: s_clk=0, s_dat=0, s_pen=1 for H cycles, then IDLE.
- Completion:
  - On the IDLE entry cycle: done=1 for one cycle, busy=0, s_pen=0.
  - start in that same cycle is accepted, giving back-to-back frames.
- Frame length: busy high for (2*DATA_W+1)*H cycles.
- par_data changes during a frame have no effect.
- rst_n low mid-frame: immediate abort to reset values. No partial latch pulse is emitted.
- Divider: a single counter of CLK_DIV+1 bits generates phase ticks. It is cleared on start and runs only outside IDLE.

Optional Feature:
- Macro: SSEG_P2S_AUTO_REFRESH_EN.
- Defined:
  - An idle counter runs in IDLE.
  - After REFRESH_CYC consecutive idle cycles without start, a frame launches as if start=1, capturing current par_data.
  - An explicit start resets the idle counter.
- Undefined: frames launch only on start; no idle counter is synthesized; REFRESH_CYC is ignored.

Decomposition:
- sseg_pkg holds:
  - state enum {IDLE, SHIFT, LATCH};
  - default DATA_W=64;
  - a helper constant for H.
- One sub-module: sseg_tick_gen. It is the divider producing the half-bit tick and the phase bit, with parameter CLK_DIV and inputs clk, rst_n, run.

Test Plan:
1. CLK_DIV=0, par_data=64'h8000_0000_0000_0001, start pulse:
   - busy high exactly 129 cycles;
   - s_dat=1 during bit 0 and bit 63, 0 otherwise;
   - 64 s_clk rising edges;
   - s_pen high 1 cycle;
   - done 1 cycle as busy falls.
2. CLK_DIV=2, par_data=64'hA5A5_F00F_0123_4567:
   - sample s_dat on each s_clk rise and reconstruct the word;
   - s_dat stable 4 cycles before and 4 cycles after each rise.
3. start held high continuously, par_data alternating 0 and all-ones per frame: frames run back-to-back with no idle gap; done and start coincide; each frame carries the value captured at its start.
4. Assert rst_n=0 at bit 20 of a frame: all outputs are 0 in the same cycle with no s_pen pulse; s_clr_n returns to 1 one edge after release; the next start produces a correct full frame.
5. par_data changed and start re-pulsed mid-frame: ignored; the shifted word equals the originally captured value; busy length is unchanged.
6. SSEG_P2S_AUTO_REFRESH_EN defined, REFRESH_CYC=10, no start: a frame launches after 10 idle cycles and repeats every 10 + frame-length cycles. With the macro undefined, no frame ever launches.
